// File: rtl/multiword_add_sequencer.sv
// Multi-precision add/subtract engine: one WIDTH-bit carry-lookahead adder is
// reused across WORDS cycles, least-significant word first, with a carry register.

module cla_adder #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             c_i,
  output logic [WIDTH-1:0] sum_o,
  output logic             c_o
);

  logic [WIDTH-1:0] gen;
  logic [WIDTH-1:0] prop;
  logic [WIDTH:0]   carry;
  logic             c_acc;
  logic             p_acc;

  // Each carry is the flat lookahead sum of generate terms gated by the
  // propagates above them, so no carry depends on a neighbouring carry.
  always_comb begin
    gen      = a_i & b_i;
    prop     = a_i ^ b_i;
    carry    = '0;
    carry[0] = c_i;
    c_acc    = 1'b0;
    p_acc    = 1'b0;
    for (int i = 0; i < WIDTH; i++) begin
      c_acc = gen[i];
      p_acc = prop[i];
      for (int j = i - 1; j >= 0; j--) begin
        c_acc = c_acc | (p_acc & gen[j]);
        p_acc = p_acc & prop[j];
      end
      carry[i+1] = c_acc | (p_acc & c_i);
    end
  end

  assign sum_o = prop ^ carry[WIDTH-1:0];
  assign c_o   = carry[WIDTH];

endmodule

module multiword_add_sequencer #(
  parameter int WIDTH = 32,
  parameter int WORDS = 4
) (
  input  logic                   Clk_i,
  input  logic                   Rst_ni,
  input  logic                   Start_i,
  input  logic                   Sub_i,
  input  logic                   Carry_i,
  input  logic [WIDTH*WORDS-1:0] Number1_i,
  input  logic [WIDTH*WORDS-1:0] Number2_i,
  output logic                   Ready_o,
  output logic                   Done_o,
  output logic [WIDTH*WORDS-1:0] Result_o,
  output logic                   Carry_o,
  output logic                   Overflow_o
);

  localparam int N     = WIDTH * WORDS;
  localparam int IDX_W = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORDS - 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_e;

  state_e           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             carry_q, carry_d;
  logic [N-1:0]     result_q, result_d;
  logic             carry_out_q, carry_out_d;
  logic             overflow_q, overflow_d;
  logic [N-1:0]     op_a_q, op_a_d;
  logic [N-1:0]     op_b_q, op_b_d;

  logic [WIDTH-1:0] word_a;
  logic [WIDTH-1:0] word_b;
  logic [WIDTH-1:0] word_sum;
  logic             word_co;

  assign word_a = op_a_q[idx_q*WIDTH +: WIDTH];
  assign word_b = op_b_q[idx_q*WIDTH +: WIDTH];

  cla_adder #(
    .WIDTH (WIDTH)
  ) u_adder (
    .a_i   (word_a),
    .b_i   (word_b),
    .c_i   (carry_q),
    .sum_o (word_sum),
    .c_o   (word_co)
  );

  always_comb begin
    // NOTE: every signal gets its hold value first so no path through the case infers a latch.
    state_d     = state_q;
    idx_d       = idx_q;
    carry_d     = carry_q;
    result_d    = result_q;
    carry_out_d = carry_out_q;
    overflow_d  = overflow_q;
    op_a_d      = op_a_q;
    op_b_d      = op_b_q;

    unique case (state_q)
      IDLE: begin
        if (Start_i) begin
          op_a_d  = Number1_i;
          op_b_d  = Sub_i ? ~Number2_i : Number2_i;
          // Subtract is A + ~B + 1, so the forced carry-in replaces Carry_i.
          carry_d = Sub_i | Carry_i;
          idx_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        result_d[idx_q*WIDTH +: WIDTH] = word_sum;
        carry_d = word_co;
        if (idx_q == LAST_IDX) begin
          carry_out_d = word_co;
          overflow_d  = (op_a_q[N-1] == op_b_q[N-1]) && (word_sum[WIDTH-1] != op_a_q[N-1]);
          state_d     = DONE;
        end else begin
          idx_d = idx_q + IDX_W'(1);
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clk_i or negedge Rst_ni) begin
    if (!Rst_ni) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      carry_q     <= 1'b0;
      result_q    <= '0;
      carry_out_q <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      state_q     <= state_d;
      idx_q       <= idx_d;
      carry_q     <= carry_d;
      result_q    <= result_d;
      carry_out_q <= carry_out_d;
      overflow_q  <= overflow_d;
    end
  end

  // NOTE: operand registers are always loaded before use, so they carry no reset.
  always_ff @(posedge Clk_i) begin
    op_a_q <= op_a_d;
    op_b_q <= op_b_d;
  end

  assign Ready_o    = (state_q == IDLE);
  assign Done_o     = (state_q == DONE);
  assign Result_o   = result_q;
  assign Carry_o    = carry_out_q;
  assign Overflow_o = overflow_q;

endmodule

// File: tb/tb_multiword_add_sequencer.sv
// Self-checking bench for multiword_add_sequencer (WIDTH=8, WORDS=4): arithmetic
// timeline model checked every cycle, plus directed literal vectors.

module tb_multiword_add_sequencer;

  localparam int WIDTH = 8;
  localparam int WORDS = 4;
  localparam int N     = WIDTH * WORDS;

  logic         clk = 1'b0;
  logic         rst_n = 1'b1;
  logic         Start_i = 1'b0;
  logic         Sub_i = 1'b0;
  logic         Carry_i = 1'b0;
  logic [N-1:0] Number1_i = '0;
  logic [N-1:0] Number2_i = '0;
  logic         Ready_o;
  logic         Done_o;
  logic [N-1:0] Result_o;
  logic         Carry_o;
  logic         Overflow_o;

  int checks = 0;
  int errors = 0;

  multiword_add_sequencer #(
    .WIDTH (WIDTH),
    .WORDS (WORDS)
  ) dut (
    .Clk_i      (clk),
    .Rst_ni     (rst_n),
    .Start_i    (Start_i),
    .Sub_i      (Sub_i),
    .Carry_i    (Carry_i),
    .Number1_i  (Number1_i),
    .Number2_i  (Number2_i),
    .Ready_o    (Ready_o),
    .Done_o     (Done_o),
    .Result_o   (Result_o),
    .Carry_o    (Carry_o),
    .Overflow_o (Overflow_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Plain arithmetic view of the operation, independent of word slicing.
  function automatic void model(input logic [N-1:0] a, input logic [N-1:0] b,
                                input logic sub, input logic cin,
                                output logic [N-1:0] r, output logic c, output logic v);
    logic [N:0] t;
    if (!sub) begin
      t = {1'b0, a} + {1'b0, b} + {{N{1'b0}}, cin};
      r = t[N-1:0];
      c = t[N];
      v = (a[N-1] == b[N-1]) && (r[N-1] != a[N-1]);
    end else begin
      r = a - b;
      c = (a >= b);
      v = (a[N-1] != b[N-1]) && (r[N-1] != a[N-1]);
    end
  endfunction

  // Timeline model: an accept at edge c makes results valid after edge c+WORDS
  // and frees the engine at edge c+WORDS+1.
  int           cyc = 0;
  int           acc_cyc = -1;
  logic [N-1:0] pend_r = '0, exp_r = '0;
  logic         pend_c = 1'b0, exp_c = 1'b0;
  logic         pend_v = 1'b0, exp_v = 1'b0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_cyc = -1;
      exp_r   = '0;
      exp_c   = 1'b0;
      exp_v   = 1'b0;
    end else begin
      cyc++;
      if (acc_cyc < 0) begin
        if (Start_i) begin
          acc_cyc = cyc;
          model(Number1_i, Number2_i, Sub_i, Carry_i, pend_r, pend_c, pend_v);
        end
      end else if (cyc - acc_cyc == WORDS) begin
        exp_r = pend_r;
        exp_c = pend_c;
        exp_v = pend_v;
      end else if (cyc - acc_cyc == WORDS + 1) begin
        acc_cyc = -1;
      end
    end
  end

  int since_m;
  always @(negedge clk) begin
    if (rst_n) begin
      since_m = (acc_cyc < 0) ? -1 : cyc - acc_cyc;
      check("ready", 64'(Ready_o), 64'(acc_cyc < 0));
      check("done", 64'(Done_o), 64'(since_m == WORDS));
      if (acc_cyc < 0 || since_m == WORDS) begin
        check("result", 64'(Result_o), 64'(exp_r));
        check("carry", 64'(Carry_o), 64'(exp_c));
        check("overflow", 64'(Overflow_o), 64'(exp_v));
      end
    end
  end

  task automatic run_op(input string name, input logic [N-1:0] a, input logic [N-1:0] b,
                        input logic sub, input logic cin,
                        input logic [N-1:0] er, input logic ec, input logic ev);
    int n;
    @(posedge clk);
    #2;
    Number1_i = a;
    Number2_i = b;
    Sub_i     = sub;
    Carry_i   = cin;
    Start_i   = 1'b1;
    @(posedge clk);
    #2;
    Start_i   = 1'b0;
    Number1_i = $urandom;
    Number2_i = $urandom;
    Sub_i     = ~sub;
    Carry_i   = ~cin;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!Done_o && n < 20);
    check({name, "_latency"}, 64'(n), 64'(WORDS + 1));
    check({name, "_result"}, 64'(Result_o), 64'(er));
    check({name, "_carry"}, 64'(Carry_o), 64'(ec));
    check({name, "_ovf"}, 64'(Overflow_o), 64'(ev));
    @(negedge clk);
    check({name, "_done_pulse"}, 64'(Done_o), 64'(0));
    check({name, "_ready_back"}, 64'(Ready_o), 64'(1));
    check({name, "_result_hold"}, 64'(Result_o), 64'(er));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, checks %0d", checks);
    $fatal(1, "watchdog expired");
  end

  logic rdy_s [30];
  int   last_i, nacc, n;

  initial begin
    #1 rst_n = 1'b0;
    #1;
    check("rst_ready", 64'(Ready_o), 64'(1));
    check("rst_done", 64'(Done_o), 64'(0));
    check("rst_result", 64'(Result_o), 64'(0));
    check("rst_carry", 64'(Carry_o), 64'(0));
    check("rst_ovf", 64'(Overflow_o), 64'(0));
    #10 rst_n = 1'b1;

    run_op("add_ff_1",     32'h000000FF, 32'h00000001, 1'b0, 1'b0, 32'h00000100, 1'b0, 1'b0);
    run_op("ripple",       32'hFFFFFFFF, 32'h00000000, 1'b0, 1'b1, 32'h00000000, 1'b1, 1'b0);
    run_op("add_ovf",      32'h7FFFFFFF, 32'h00000001, 1'b0, 1'b0, 32'h80000000, 1'b0, 1'b1);
    run_op("sub_ovf",      32'h80000000, 32'h00000001, 1'b1, 1'b0, 32'h7FFFFFFF, 1'b1, 1'b1);
    run_op("sub_borrow",   32'h00000005, 32'h00000007, 1'b1, 1'b1, 32'hFFFFFFFE, 1'b0, 1'b0);
    run_op("add_neg_ovf",  32'h80000000, 32'h80000000, 1'b0, 1'b0, 32'h00000000, 1'b1, 1'b1);

    // Start held high with operands changing every cycle.
    @(posedge clk);
    #2;
    Start_i   = 1'b1;
    Number1_i = $urandom;
    Number2_i = $urandom;
    Sub_i     = 1'($urandom_range(0, 1));
    Carry_i   = 1'($urandom_range(0, 1));
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      rdy_s[i] = Ready_o;
      @(posedge clk);
      #2;
      Number1_i = $urandom;
      Number2_i = $urandom;
      Sub_i     = 1'($urandom_range(0, 1));
      Carry_i   = 1'($urandom_range(0, 1));
    end
    Start_i = 1'b0;
    last_i  = -1;
    nacc    = 0;
    for (int i = 0; i < 30; i++) begin
      if (rdy_s[i]) begin
        if (last_i >= 0) check("accept_gap", 64'(i - last_i), 64'(WORDS + 2));
        last_i = i;
        nacc++;
      end
    end
    check("accept_count", 64'(nacc), 64'(5));
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!Ready_o && n < 20);
    check("b2b_drain", 64'(Ready_o), 64'(1));

    // Abort mid-RUN with an asynchronous reset.
    @(posedge clk);
    #2;
    Number1_i = 32'hAAAA5555;
    Number2_i = 32'h13572468;
    Sub_i     = 1'b0;
    Carry_i   = 1'b1;
    Start_i   = 1'b1;
    @(posedge clk);
    #2;
    Start_i = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    check("abort_result", 64'(Result_o), 64'(0));
    check("abort_ready", 64'(Ready_o), 64'(1));
    check("abort_done", 64'(Done_o), 64'(0));
    check("abort_carry", 64'(Carry_o), 64'(0));
    check("abort_ovf", 64'(Overflow_o), 64'(0));
    @(posedge clk);
    @(posedge clk);
    #2 rst_n = 1'b1;
    repeat (6) @(negedge clk);

    run_op("after_reset", 32'h12345678, 32'h11111111, 1'b0, 1'b0, 32'h23456789, 1'b0, 1'b0);

    repeat (2) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
